uart_word_loader: RTL and testbench

Receive-side counterpart of the ASCII bit-stream transmitter. Deserialises 8N1 UART characters from `RxD`, parses ASCII '0'/'1' digits MSB-first into `DATAWIDTH`-bit words, and writes each completed word into the shared number RAM. Words are written at consecutive addresses 0..`DATADEPTH`-1. The RAM layout matches what the transmit path reads back.

---
 rtl/uart_word_loader.sv | 191 +++++++++++++++++++
 tb/tb_uart_word_loader.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_word_loader.sv
// UART receive path that turns ASCII '0'/'1' digit strings into DATAWIDTH-bit words
// and writes them to consecutive RAM addresses until DATADEPTH words are stored.
module uart_word_loader #(
    parameter int DATAWIDTH    = 8,
    parameter int DATADEPTH    = 16,
    parameter int CLKS_PER_BIT = 10417
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RxD,
    output logic                 we,
    output logic [20:0]          address,
    output logic [DATAWIDTH-1:0] data_out,
    output logic                 done,
    output logic                 frame_err,
    output logic                 fmt_err
);

    // state   | meaning
    // S_IDLE  | line idle, waiting for a low synced RxD
    // S_START | half-bit wait, then confirm the start bit is still low
    // S_DATA  | sample 8 data bits LSB first, one per bit time
    // S_STOP  | sample stop bit; high -> byte valid, low -> framing error
    // S_BREAK | after a framing error, wait for the line to return high
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} rx_state_t;

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int CW = $clog2(DATAWIDTH + 1);
    localparam logic [TW-1:0] HALF_BIT = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] FULL_BIT = TW'(CLKS_PER_BIT - 1);
    localparam logic [TW-1:0] T_ONE    = TW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DATAWIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [20:0]   ADDR_LAST = 21'(DATADEPTH - 1);

    rx_state_t      state_q;
    logic           sync1_q, sync2_q;
    logic [TW-1:0]  timer_q;
    logic [2:0]     bit_idx_q;
    logic [7:0]     rx_byte_q;
    logic           rx_valid_q;
    logic           frame_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            state_q     <= S_IDLE;
            timer_q     <= '0;
            bit_idx_q   <= '0;
            rx_byte_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q    <= RxD;
            sync2_q    <= sync1_q;
            rx_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!sync2_q) begin
                        state_q <= S_START;
                        timer_q <= HALF_BIT;
                    end
                end
                S_START: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - T_ONE;
                    end else if (!sync2_q) begin
                        state_q   <= S_DATA;
                        timer_q   <= FULL_BIT;
                        bit_idx_q <= '0;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_DATA: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - T_ONE;
                    end else begin
                        rx_byte_q <= {sync2_q, rx_byte_q[7:1]};
                        timer_q   <= FULL_BIT;
                        bit_idx_q <= bit_idx_q + 3'd1;
                        if (bit_idx_q == 3'd7) state_q <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (timer_q != '0) begin
                        timer_q <= timer_q - T_ONE;
                    end else if (sync2_q) begin
                        rx_valid_q <= 1'b1;
                        state_q    <= S_IDLE;
                    end else begin
                        frame_err_q <= 1'b1;
                        state_q     <= S_BREAK;
                    end
                end
                S_BREAK: begin
                    if (sync2_q) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    logic [DATAWIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [20:0]          addr_q, addr_d;
    logic [DATAWIDTH-1:0] data_q, data_d;
    logic                 done_q, done_d;
    logic                 fmt_q, fmt_d;
    logic                 is_digit, is_delim, is_abort;

    always_comb begin
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        data_d   = data_q;
        done_d   = done_q;
        fmt_d    = fmt_q;
        is_digit = (rx_byte_q == 8'h30) || (rx_byte_q == 8'h31);
        is_delim = (rx_byte_q == 8'h20) || (rx_byte_q == 8'h0D) || (rx_byte_q == 8'h0A);
        is_abort = (rx_byte_q == 8'h5F);

        // Address advance and word clear happen the cycle after the write strobe.
        if (we_q) begin
            shreg_d = '0;
            cnt_d   = '0;
            if (addr_q == ADDR_LAST) begin
                addr_d = '0;
                done_d = 1'b1;
            end else begin
                addr_d = addr_q + 21'd1;
            end
        end

        if (rx_valid_q && !done_q) begin
            if (is_digit) begin
                if (cnt_q == CNT_FULL) begin
                    fmt_d   = 1'b1;
                    shreg_d = '0;
                    cnt_d   = '0;
                end else begin
                    shreg_d = {shreg_q[DATAWIDTH-2:0], rx_byte_q[0]};
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end else if (is_delim) begin
                if (cnt_q == CNT_FULL) begin
                    data_d = shreg_q;
                    we_d   = 1'b1;
                end else if (cnt_q != '0) begin
                    fmt_d   = 1'b1;
                    shreg_d = '0;
                    cnt_d   = '0;
                end
            end else if (is_abort) begin
                shreg_d = '0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= '0;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
            done_q  <= 1'b0;
            fmt_q   <= 1'b0;
        end else begin
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            done_q  <= done_d;
            fmt_q   <= fmt_d;
        end
    end

    assign we        = we_q;
    assign address   = addr_q;
    assign data_out  = data_q;
    assign done      = done_q;
    assign frame_err = frame_err_q;
    assign fmt_err   = fmt_q;

endmodule

// File: tb/tb_uart_word_loader.sv
// Randomised and directed bench for uart_word_loader, checked against a
// character-level model of the word parser.
module tb_uart_word_loader;

    localparam int CPB = 16;
    localparam int W   = 8;
    localparam int D   = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         RxD = 1'b1;
    logic         we;
    logic [20:0]  address;
    logic [W-1:0] data_out;
    logic         done, frame_err, fmt_err;

    uart_word_loader #(.DATAWIDTH(W), .DATADEPTH(D), .CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rst(rst), .RxD(RxD), .we(we), .address(address),
        .data_out(data_out), .done(done), .frame_err(frame_err), .fmt_err(fmt_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         addr;
        logic [7:0] data;
    } wr_t;

    int         n_tests = 0;
    int         n_fail  = 0;
    wr_t        exp_q[$];
    logic [7:0] m_word;
    int         m_cnt, m_addr;
    bit         m_done, m_fmt, m_frame;
    logic [7:0] m_last;
    logic [7:0] last_data;
    int         last_addr;
    int         n_we = 0;
    bit         prev_we = 1'b0;
    int         prev_addr = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_word = '0; m_cnt = 0; m_addr = 0;
        m_done = 0; m_fmt = 0; m_frame = 0; m_last = '0;
    endtask

    task automatic model_char(input logic [7:0] c, input bit stop_ok);
        wr_t w;
        if (!stop_ok) begin
            m_frame = 1;
            return;
        end
        if (m_done) return;
        if (c == "0" || c == "1") begin
            if (m_cnt < W) begin
                m_word = {m_word[6:0], c[0]};
                m_cnt++;
            end else begin
                m_fmt = 1; m_word = '0; m_cnt = 0;
            end
        end else if (c == 8'h20 || c == 8'h0D || c == 8'h0A) begin
            if (m_cnt == W) begin
                w.addr = m_addr; w.data = m_word;
                exp_q.push_back(w);
                m_last = m_word;
                m_addr = (m_addr + 1) % D;
                if (m_addr == 0) m_done = 1;
                m_word = '0; m_cnt = 0;
            end else if (m_cnt != 0) begin
                m_fmt = 1; m_word = '0; m_cnt = 0;
            end
        end else if (c == 8'h5F) begin
            m_word = '0; m_cnt = 0;
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_char(input logic [7:0] c, input bit stop_ok);
        model_char(c, stop_ok);
        RxD = 1'b0;
        tick(CPB);
        for (int i = 0; i < 8; i++) begin
            RxD = c[i];
            tick(CPB);
        end
        RxD = stop_ok;
        tick(CPB);
        RxD = 1'b1;
        tick(2);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_char(s[i], 1'b1);
    endtask

    task automatic send_word(input logic [7:0] v, input logic [7:0] delim);
        for (int i = 7; i >= 0; i--) send_char(8'h30 | {7'd0, v[i]}, 1'b1);
        send_char(delim, 1'b1);
    endtask

    task automatic do_reset();
        RxD = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        model_reset();
        tick(2);
    endtask

    task automatic chk(input string tag);
        tick(4);
        check({tag, "_we"},        we, 1'b0);
        check({tag, "_address"},   address, m_addr);
        check({tag, "_data_out"},  data_out, m_last);
        check({tag, "_done"},      done, m_done);
        check({tag, "_fmt_err"},   fmt_err, m_fmt);
        check({tag, "_frame_err"}, frame_err, m_frame);
        check({tag, "_pending_writes"}, exp_q.size(), 0);
    endtask

    // Every write strobe is matched against the model's queue of expected writes.
    always @(negedge clk) begin
        if (rst) begin
            prev_we = 1'b0;
        end else begin
            if (prev_we) begin
                check("addr_after_we", address, (prev_addr + 1) % D);
                check("done_after_we", done, prev_addr == D - 1);
            end
            if (we) begin
                wr_t w;
                check("we_not_back_to_back", prev_we, 1'b0);
                check("we_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    w = exp_q.pop_front();
                    check("we_address", address, w.addr);
                    check("we_data", data_out, w.data);
                end
                last_data = data_out;
                last_addr = int'(address);
                n_we++;
            end
            prev_we   = we;
            prev_addr = int'(address);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n0;
        model_reset();
        // Reset and idle line
        do_reset();
        chk("reset");
        tick(500);
        check("idle_no_we", n_we, 0);
        chk("idle");

        // Single word then delimiters only
        send_str("10110010 ");
        chk("w_b2");
        check("w_b2_lit_data", last_data, 8'hB2);
        check("w_b2_lit_addr", last_addr, 0);
        check("w_b2_lit_next_addr", address, 1);
        n0 = n_we;
        send_str("  ");
        send_char(8'h0D, 1'b1);
        send_char(8'h0A, 1'b1);
        check("delims_no_we", n_we, n0);
        chk("delims");

        // Fill all DATADEPTH words
        do_reset();
        for (int v = 0; v < D; v++) send_word(v[7:0], 8'h20);
        chk("fill");
        check("fill_lit_done", done, 1'b1);
        check("fill_lit_addr", address, 0);
        check("fill_lit_last", last_data, 8'h0F);
        check("fill_lit_last_addr", last_addr, 15);
        n0 = n_we;
        send_str("11111111 ");
        check("after_done_no_we", n_we, n0);
        chk("after_done");

        // Format errors and abort
        do_reset();
        n0 = n_we;
        send_str("101 ");
        check("short_no_we", n_we, n0);
        check("short_lit_fmt", fmt_err, 1'b1);
        chk("short");
        send_str("1010_11110000 ");
        check("abort_lit_data", last_data, 8'hF0);
        check("abort_lit_addr", last_addr, 0);
        chk("abort");
        n0 = n_we;
        send_str("111111111 ");
        check("long_no_we", n_we, n0);
        check("long_lit_fmt", fmt_err, 1'b1);
        chk("long");

        // Glitch and framing error
        do_reset();
        RxD = 1'b0;
        tick(4);
        RxD = 1'b1;
        tick(20);
        check("glitch_no_we", n_we, n0 + 1 - 1);
        chk("glitch");
        send_char(8'h31, 1'b0);
        tick(10);
        check("frame_lit", frame_err, 1'b1);
        chk("frame");
        send_str("00000001 ");
        check("frame_then_word_lit", last_data, 8'h01);
        check("frame_then_word_fmt_lit", fmt_err, 1'b0);
        chk("frame_word");

        // Reset in the middle of a character, in the middle of a word
        do_reset();
        send_str("1111");
        RxD = 1'b0;
        tick(CPB);
        for (int i = 0; i < 3; i++) begin
            RxD = 1'b1 & (i != 1);
            tick(CPB);
        end
        RxD = 1'b0;
        tick(CPB / 2);
        n0 = n_we;
        rst = 1'b1;
        tick(2);
        RxD = 1'b1;
        tick(1);
        rst = 1'b0;
        model_reset();
        tick(20 * CPB);
        check("midreset_no_we", n_we, n0);
        chk("midreset");
        send_str("11001100 ");
        check("midreset_word_lit", last_data, 8'hCC);
        check("midreset_addr_lit", last_addr, 0);
        chk("midreset_word");

        // Random tokens
        do_reset();
        for (int t = 0; t < 20; t++) begin
            if ($urandom_range(0, 9) < 7) begin
                logic [7:0] dl;
                case ($urandom_range(0, 2))
                    0: dl = 8'h20;
                    1: dl = 8'h0D;
                    default: dl = 8'h0A;
                endcase
                send_word(8'($urandom_range(0, 255)), dl);
            end else begin
                logic [7:0] c;
                case ($urandom_range(0, 5))
                    0: c = "0";
                    1: c = "1";
                    2: c = 8'h20;
                    3: c = 8'h5F;
                    4: c = "x";
                    default: c = 8'h0A;
                endcase
                send_char(c, $urandom_range(0, 7) != 0);
            end
            chk("random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
